cic_decimator: RTL and testbench
================================

# cic_decimator

PDM-to-PCM decimation stage for one microphone channel. Converts a 1-bit PDM stream into signed 18-bit PCM samples with a 4th-order CIC filter. Sits directly upstream of the per-channel `sync_fifo`: `pcm_data`/`pcm_valid` drive the FIFO's `d_in`/`wr_en`, and the FIFO's `full` comes back as `fifo_full`.

## Interface
- `DECIM`, default 64: decimation ratio R in PDM ticks per output sample; power of two, range 8..256.
- `OUT_WIDTH`, default 18: PCM sample width; matches the FIFO `WIDTH`.
- `clk` in 1: system clock.
- `rst` in 1: reset; one clock; reset is asynchronous and active-high.
- `en` in 1: block enable; low acts as a synchronous clear.
- `pdm_en` in 1: one-cycle strobe marking a valid PDM bit.
- `pdm_data` in 1: PDM bit, sampled only when `pdm_en` is high.
- `fifo_full` in 1: downstream FIFO full flag.
- `pcm_data` out OUT_WIDTH: signed PCM sample.
- `pcm_valid` out 1: one-cycle write strobe to the FIFO.
- `ovf_cnt` out 16: count of dropped samples (see Configuration).

## Operation
- Input mapping: `pdm_data`=1 gives +1, and 0 gives −1, as signed two's complement.
- Filter order N=4. Internal width ACC_W = N·log2(DECIM)+2, which is 26 at defaults. All integrator and comb arithmetic is modular at ACC_W; wrap-around is intentional and must not be saturated.
- Integrators:
  - Four cascaded accumulators.
  - All four update only on cycles where `pdm_en` is high.
  - Each stage accumulates the previous stage's registered value.
- Decimation counter:
  - Counts 0..DECIM−1 on `pdm_en`.
  - On the `pdm_en` cycle where the counter equals DECIM−1, the post-update last-integrator value enters the comb pipeline and the counter wraps to 0.
- Combs:
  - Four pipelined stages, one register each, computing y = x − x_prev(decimated).
  - Each stage's delay element updates only when that stage's input is valid.
- Output scaling: `pcm_data` = comb output arithmetic-shifted right by ACC_W−OUT_WIDTH. No saturation is needed, because ±2^24 >> 8 = ±65536 fits in 18 bits.
- Warm-up state machine:
  - WARMUP: the first N decimated results after reset or clear are computed but not emitted; `pcm_valid` stays low.
  - RUN: entered after the N-th result. Every result is emitted.
- Back-pressure:
  - If `fifo_full` is high in the output cycle, `pcm_valid` stays low and the sample is discarded. The filter state still advances; there is no stall.
  - The drop is counted when the feature is enabled.
- `en` low: on the next edge, all state returns to reset values, including WARMUP and `ovf_cnt`. `pdm_en` is ignored while `en` is low.

## Timing
- Reset values: `pcm_data`=0, `pcm_valid`=0, `ovf_cnt`=0. All accumulators, comb delays, the decimation counter and the warm-up counter are 0, and the state is WARMUP.
- Asynchronous `rst` clears the outputs immediately, without a clock edge. Release is synchronous to `clk`.
- Latency: cycle T is the decimating `pdm_en` cycle. `pcm_valid` and the new `pcm_data` appear in cycle T+5 (4 comb registers plus the output register).
- `pcm_valid` is high for exactly one cycle per emitted sample. `pcm_data` holds its value until the next emitted sample.
- Constraint: `pdm_en` strobes are at least 1 cycle apart. DECIM ≥ 8 guarantees the comb pipeline never holds two samples at once.
- `fifo_full` is sampled in cycle T+4, the same edge that registers the output.
- `rst` asserted while samples are in the pipeline: in-flight samples are lost and never emitted.

## Configuration
- `CIC_OVF_CNT_EN` defined: `ovf_cnt` increments by 1 per dropped sample, saturating at 0xFFFF, and is cleared only by `rst` or `en` low.
- `CIC_OVF_CNT_EN` not defined: the counter logic is removed and `ovf_cnt` is tied to constant 0.
- In both builds, samples dropped during back-pressure are never emitted late.

## Structure
- Package `cic_pkg`:
  - `CIC_ORDER` = 4.
  - A function computing ACC_W from DECIM.
  - `pcm_t`, the signed OUT_WIDTH sample type.
- Sub-module `cic_comb_stage`, instantiated 4×: parameterised width, inputs `in_valid`/`in_data`, outputs `out_valid`/`out_data`, async active-high reset.
- Integrators, decimation counter, warm-up FSM and overflow counter live in the top module.

## Test plan
1. Defaults, `pdm_en` every 4 cycles, `pdm_data`=1 constant: first 4 results suppressed; every emitted `pcm_data` = 0x10000 (+65536), one `pcm_valid` per 64 strobes.
2. `pdm_data`=0 constant: every emitted sample = 0x30000 (−65536).
3. Alternating 1,0 from reset: every emitted sample = 0.
4. All-ones stream, `fifo_full` high across 3 output cycles: no `pcm_valid` in those slots, and the next emitted sample is still 0x10000.
   - With the macro defined: `ovf_cnt`=3.
   - Without the macro: `ovf_cnt`=0.
5. `rst` pulsed between strobes mid-stream: outputs and `ovf_cnt` read 0 before the next edge. After release, 4 results are suppressed again and the 5th = 0x10000.
6. `en` low for 1 cycle during RUN: same recovery as test 5, with the clear taking effect at the next edge.

Source files
------------

// File: rtl/cic_pkg.sv
// -----------------------------------------------------------------------------
// cic_pkg
//   Shared constants and types for the PDM-to-PCM CIC decimator.
//   - CIC_ORDER   : number of integrator / comb stages
//   - PCM_W       : default PCM sample width
//   - pcm_t       : signed PCM sample type at the default width
//   - cic_state_e : warm-up state machine encoding
//   - cic_acc_w() : internal accumulator width for a given decimation ratio
// -----------------------------------------------------------------------------
package cic_pkg;

  localparam int CIC_ORDER = 4;
  localparam int PCM_W     = 18;

  typedef logic signed [PCM_W-1:0] pcm_t;

  typedef enum logic [0:0] {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } cic_state_e;

  // DC gain of the filter is DECIM^ORDER; two extra bits hold the sign and
  // the full-scale negative swing, so modular arithmetic stays exact.
  function automatic int cic_acc_w(input int decim);
    return CIC_ORDER * $clog2(decim) + 2;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// -----------------------------------------------------------------------------
// cic_comb_stage
//   One differentiator stage of the CIC decimator: y = x - x_prev, where
//   x_prev is the previous *valid* input (the decimated-rate delay).
//   Ports:
//     clk       in  system clock
//     rst       in  asynchronous active-high reset
//     clr       in  synchronous clear (block disabled)
//     in_valid  in  input sample valid
//     in_data   in  input sample, W bits, modular two's complement
//     out_valid out registered output valid, one cycle after in_valid
//     out_data  out registered difference, W bits
// -----------------------------------------------------------------------------
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [W-1:0] dly_q,   dly_d;
  logic [W-1:0] data_q,  data_d;
  logic         valid_q, valid_d;

  // Next-state: the delay element only moves on a valid input sample.
  always_comb begin
    dly_d   = dly_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (clr) begin
      dly_d   = '0;
      data_d  = '0;
      valid_d = 1'b0;
    end else if (in_valid) begin
      dly_d   = in_data;
      data_d  = in_data - dly_q;
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dly_q   <= dly_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/cic_decimator.sv
// -----------------------------------------------------------------------------
// cic_decimator
//   4th-order CIC decimator turning a 1-bit PDM stream into signed PCM
//   samples for one microphone channel; feeds a sync FIFO directly.
//   Parameters:
//     DECIM     decimation ratio (power of two, 8..256)
//     OUT_WIDTH PCM sample width
//   Ports:
//     clk       in  system clock
//     rst       in  asynchronous active-high reset
//     en        in  block enable; low clears all state on the next edge
//     pdm_en    in  one-cycle strobe marking a valid PDM bit
//     pdm_data  in  PDM bit (1 -> +1, 0 -> -1)
//     fifo_full in  downstream FIFO full; a sample offered while full is lost
//     pcm_data  out signed PCM sample, held until the next emitted sample
//     pcm_valid out one-cycle FIFO write strobe
//     ovf_cnt   out saturating count of dropped samples
//   Build option:
//     CIC_OVF_CNT_EN  when defined, ovf_cnt counts dropped samples;
//                     otherwise it is tied to zero.
//   Result of the decimating strobe in cycle T appears in cycle T+5.
// -----------------------------------------------------------------------------
module cic_decimator
  import cic_pkg::*;
#(
  parameter int DECIM     = 64,
  parameter int OUT_WIDTH = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 pdm_en,
  input  logic                 pdm_data,
  input  logic                 fifo_full,
  output logic [OUT_WIDTH-1:0] pcm_data,
  output logic                 pcm_valid,
  output logic [15:0]          ovf_cnt
);

  localparam int ACC_W  = cic_acc_w(DECIM);
  localparam int CNT_W  = $clog2(DECIM);
  localparam int WARM_W = $clog2(CIC_ORDER);

  // ---------------------------------------------------------------------------
  // Integrators
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] integ_q [CIC_ORDER];
  logic [ACC_W-1:0] integ_d [CIC_ORDER];
  logic [ACC_W-1:0] pdm_val_s;

  // 1 -> 0...01 (+1), 0 -> 1...11 (-1)
  assign pdm_val_s = {{(ACC_W-1){~pdm_data}}, 1'b1};

  // Integrator next-state: every stage adds the previous stage's registered value.
  always_comb begin
    for (int i = 0; i < CIC_ORDER; i++) begin
      integ_d[i] = integ_q[i];
    end
    if (!en) begin
      for (int i = 0; i < CIC_ORDER; i++) begin
        integ_d[i] = '0;
      end
    end else if (pdm_en) begin
      integ_d[0] = integ_q[0] + pdm_val_s;
      for (int i = 1; i < CIC_ORDER; i++) begin
        integ_d[i] = integ_q[i] + integ_q[i-1];
      end
    end else begin
      for (int i = 0; i < CIC_ORDER; i++) begin
        integ_d[i] = integ_q[i];
      end
    end
  end

  // Integrator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CIC_ORDER; i++) begin
        integ_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CIC_ORDER; i++) begin
        integ_q[i] <= integ_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Decimation counter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
  logic             dec_s;

  assign dec_s = en & pdm_en & (dec_cnt_q == CNT_W'(DECIM - 1));

  // Decimation counter next-state.
  always_comb begin
    dec_cnt_d = dec_cnt_q;
    if (!en) begin
      dec_cnt_d = '0;
    end else if (dec_s) begin
      dec_cnt_d = '0;
    end else if (pdm_en) begin
      dec_cnt_d = dec_cnt_q + CNT_W'(1);
    end else begin
      dec_cnt_d = dec_cnt_q;
    end
  end

  // Decimation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt_q <= '0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Comb pipeline: stage 0 is fed the post-update last integrator so that the
  // decimating strobe itself lands in the first comb register.
  // ---------------------------------------------------------------------------
  logic             comb_valid_s [CIC_ORDER+1];
  logic [ACC_W-1:0] comb_data_s  [CIC_ORDER+1];
  logic             clr_s;

  assign clr_s           = ~en;
  assign comb_valid_s[0] = dec_s;
  assign comb_data_s[0]  = integ_d[CIC_ORDER-1];

  for (genvar g = 0; g < CIC_ORDER; g++) begin : g_comb
    cic_comb_stage #(
      .W (ACC_W)
    ) u_comb (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr_s),
      .in_valid  (comb_valid_s[g]),
      .in_data   (comb_data_s[g]),
      .out_valid (comb_valid_s[g+1]),
      .out_data  (comb_data_s[g+1])
    );
  end

  logic                 res_valid_s;
  logic [OUT_WIDTH-1:0] scaled_s;

  assign res_valid_s = comb_valid_s[CIC_ORDER];

  // Full scale is +/-2^(ACC_W-2); scaling keeps it inside OUT_WIDTH.
  if (ACC_W >= OUT_WIDTH) begin : g_shr
    assign scaled_s = OUT_WIDTH'($signed(comb_data_s[CIC_ORDER]) >>> (ACC_W - OUT_WIDTH));
  end else begin : g_sext
    assign scaled_s = {{(OUT_WIDTH-ACC_W){comb_data_s[CIC_ORDER][ACC_W-1]}},
                       comb_data_s[CIC_ORDER]};
  end

  // ---------------------------------------------------------------------------
  // Warm-up FSM: the first CIC_ORDER results carry start-up transients.
  // ---------------------------------------------------------------------------
  cic_state_e        state_q, state_d;
  logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
  logic              emit_s;
`ifdef CIC_OVF_CNT_EN
  logic              drop_s;
`endif

  // FSM state and warm-up counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_WARMUP;
      warm_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  // FSM next-state: leave WARMUP on the CIC_ORDER-th result (itself suppressed).
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    if (!en) begin
      state_d    = ST_WARMUP;
      warm_cnt_d = '0;
    end else begin
      case (state_q)
        ST_WARMUP: begin
          if (res_valid_s) begin
            if (warm_cnt_q == WARM_W'(CIC_ORDER - 1)) begin
              state_d    = ST_RUN;
              warm_cnt_d = '0;
            end else begin
              warm_cnt_d = warm_cnt_q + WARM_W'(1);
            end
          end else begin
            warm_cnt_d = warm_cnt_q;
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d    = ST_WARMUP;
          warm_cnt_d = '0;
        end
      endcase
    end
  end

  // FSM outputs: emit when running and the FIFO has room, otherwise the sample is lost.
  always_comb begin
    emit_s = 1'b0;
`ifdef CIC_OVF_CNT_EN
    drop_s = 1'b0;
`endif
    if (en && (state_q == ST_RUN) && res_valid_s) begin
      emit_s = ~fifo_full;
`ifdef CIC_OVF_CNT_EN
      drop_s = fifo_full;
`endif
    end else begin
      emit_s = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic [OUT_WIDTH-1:0] pcm_data_q, pcm_data_d;
  logic                 pcm_valid_q, pcm_valid_d;

  // Output next-state: data holds between emitted samples.
  always_comb begin
    pcm_data_d  = pcm_data_q;
    pcm_valid_d = 1'b0;
    if (!en) begin
      pcm_data_d  = '0;
      pcm_valid_d = 1'b0;
    end else if (emit_s) begin
      pcm_data_d  = scaled_s;
      pcm_valid_d = 1'b1;
    end else begin
      pcm_valid_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcm_data_q  <= '0;
      pcm_valid_q <= 1'b0;
    end else begin
      pcm_data_q  <= pcm_data_d;
      pcm_valid_q <= pcm_valid_d;
    end
  end

  assign pcm_data  = pcm_data_q;
  assign pcm_valid = pcm_valid_q;

  // ---------------------------------------------------------------------------
  // Dropped-sample counter
  // ---------------------------------------------------------------------------
`ifdef CIC_OVF_CNT_EN
  logic [15:0] ovf_q, ovf_d;

  // Overflow counter next-state, saturating at all-ones.
  always_comb begin
    ovf_d = ovf_q;
    if (!en) begin
      ovf_d = 16'h0000;
    end else if (drop_s && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'h0001;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 16'h0000;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_cnt = ovf_q;
`else
  assign ovf_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cic_decimator.sv
// -----------------------------------------------------------------------------
// tb_cic_decimator
//   Scoreboard bench: the stimulus side tracks the decimation phase and
//   warm-up count and pushes {expected sample, expected cycle} whenever a
//   result should be emitted; a negedge monitor pops and compares on every
//   pcm_valid. Expected sample values are hand-computed constants:
//     all ones  -> +2^24 >> 8 = 18'h10000
//     all zeros -> -2^24 >> 8 = 18'h30000
//     1,0,1,0   -> 0 (even DECIM puts a transfer zero at Nyquist)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cic_decimator;
  import cic_pkg::*;

  localparam int DEC = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pdm_en;
  logic        pdm_data;
  logic        fifo_full;
  logic [17:0] pcm_data;
  logic        pcm_valid;
  logic [15:0] ovf_cnt;

  cic_decimator #(.DECIM(DEC), .OUT_WIDTH(18)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pdm_en    (pdm_en),
    .pdm_data  (pdm_data),
    .fifo_full (fifo_full),
    .pcm_data  (pcm_data),
    .pcm_valid (pcm_valid),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          sb_cnt  = 0;
  int          warm_n  = 0;
  int          exp_drops = 0;
  logic [17:0] exp_val = 18'h00000;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pcm_valid must match the oldest expected sample and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (pcm_valid === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: pcm_data=%h at cycle %0d, no sample expected", pcm_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (pcm_data !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL sample: got %h at cycle %0d, expected %h at cycle %0d",
                   pcm_data, cyc, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic model_clear();
    sb_cnt = 0;
    warm_n = 0;
    exp_q.delete();
  endtask

  // One PDM strobe followed by three idle cycles; updates the reference model.
  task automatic send_strobe(input logic b);
    exp_t e;
    @(negedge clk);
    pdm_en   = 1'b1;
    pdm_data = b;
    if (sb_cnt == DEC - 1) begin
      sb_cnt = 0;
      if (warm_n < CIC_ORDER) begin
        warm_n++;
      end else if (fifo_full) begin
        exp_drops++;
      end else begin
        e.data = exp_val;
        e.cyc  = cyc + 5;
        exp_q.push_back(e);
      end
    end else begin
      sb_cnt++;
    end
    @(negedge clk);
    pdm_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // mode: 0 = zeros, 1 = ones, 2 = alternating 1,0
  task automatic run_blocks(input int mode, input logic full, input int nblk);
    fifo_full = full;
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < DEC; i++) begin
        if (mode == 2) send_strobe((i % 2) == 0);
        else           send_strobe(mode == 1);
      end
      repeat (8) @(negedge clk);
    end
    fifo_full = 1'b0;
  endtask

  task automatic en_clear();
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    model_clear();
  endtask

  initial begin
    logic [15:0] exp_ovf;
    rst = 1'b1; en = 1'b1; pdm_en = 1'b0; pdm_data = 1'b0; fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_pcm_data", pcm_data, 18'h00000);
    chk("reset_pcm_valid", pcm_valid, 1'b0);
    chk("reset_ovf_cnt", ovf_cnt, 16'h0000);
    rst = 1'b0;
    model_clear();

    // 1: all ones, first 4 results suppressed
    exp_val = 18'h10000;
    run_blocks(1, 1'b0, 7);
    chk("t1_drained", exp_q.size(), 0);

    // 2: all zeros
    en_clear();
    exp_val = 18'h30000;
    run_blocks(0, 1'b0, 7);
    chk("t2_drained", exp_q.size(), 0);
    chk("t2_hold", pcm_data, 18'h30000);

    // 3: alternating
    en_clear();
    exp_val = 18'h00000;
    run_blocks(2, 1'b0, 6);
    chk("t3_drained", exp_q.size(), 0);

    // 4: back-pressure across three output slots
    en_clear();
    exp_val   = 18'h10000;
    exp_drops = 0;
    run_blocks(1, 1'b0, 5);
    run_blocks(1, 1'b1, 3);
    run_blocks(1, 1'b0, 2);
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_drops_model", exp_drops, 3);
`ifdef CIC_OVF_CNT_EN
    exp_ovf = 16'(exp_drops);
`else
    exp_ovf = 16'h0000;
`endif
    chk("t4_ovf_cnt", ovf_cnt, exp_ovf);

    // 5: async reset with a sample in flight
    for (int i = 0; i < DEC; i++) send_strobe(1'b1);
    chk("t5_inflight", exp_q.size(), 1);
    chk("t5_ovf_before", ovf_cnt, exp_ovf);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_pcm_data", pcm_data, 18'h00000);
    chk("t5_async_pcm_valid", pcm_valid, 1'b0);
    chk("t5_async_ovf_cnt", ovf_cnt, 16'h0000);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    run_blocks(1, 1'b0, 5);
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_hold", pcm_data, 18'h10000);

    // 6: en low for one cycle mid-stream; pdm_en during it is ignored
    for (int i = 0; i < 30; i++) send_strobe(1'b1);
    @(negedge clk);
    en = 1'b0; pdm_en = 1'b1; pdm_data = 1'b0;
    #1;
    chk("t6_pre_clear", pcm_data, 18'h10000);
    @(posedge clk);
    #1;
    chk("t6_clear_pcm_data", pcm_data, 18'h00000);
    chk("t6_clear_pcm_valid", pcm_valid, 1'b0);
    chk("t6_clear_ovf_cnt", ovf_cnt, 16'h0000);
    @(negedge clk);
    en = 1'b1; pdm_en = 1'b0;
    model_clear();
    run_blocks(1, 1'b0, 5);
    chk("t6_drained", exp_q.size(), 0);
    chk("t6_hold", pcm_data, 18'h10000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
